lcd_bus_ctrl: RTL

LCD_BUS_CTRL -- requirements
Module: lcd_bus_ctrl

---
 rtl/lcd_bus_ctrl.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/lcd_bus_ctrl.sv
// LCD1602 (HD44780) parallel bus controller: turns one request into timed E strobes
// on an 8-bit or 4-bit bus, optionally polling the busy flag after every write.
module lcd_bus_ctrl #(
   parameter int BUS_4BIT   = 0,
   parameter int SETUP_CYC  = 2,
   parameter int E_HIGH_CYC = 11,
   parameter int E_LOW_CYC  = 16,
   parameter int POLL_BUSY  = 0,
   parameter int BUSY_MAX   = 255
) (
   input  logic       Clk,
   input  logic       Rst_n,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_rs,
   input  logic       req_rw,
   input  logic [7:0] req_data,
   output logic       done,
   output logic       done_err,
   output logic [7:0] rsp_data,
   output logic       LCD1602_RS,
   output logic       LCD1602_RW,
   output logic       LCD1602_E,
   output logic [7:0] LCD1602_DB_o,
   output logic       LCD1602_DB_oe,
   input  logic [7:0] LCD1602_DB_i
);

   localparam int T_MAX = (SETUP_CYC > E_HIGH_CYC)
                        ? ((SETUP_CYC  > E_LOW_CYC) ? SETUP_CYC  : E_LOW_CYC)
                        : ((E_HIGH_CYC > E_LOW_CYC) ? E_HIGH_CYC : E_LOW_CYC);
   localparam int CNT_W  = $clog2(T_MAX + 1);
   localparam int POLL_W = $clog2(BUSY_MAX + 1);

   localparam logic [CNT_W-1:0]  LD_SETUP  = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0]  LD_E_HI   = CNT_W'(E_HIGH_CYC - 1);
   // E_LO holds the bus for E_LOW_CYC full cycles after the cycle in which E falls
   localparam logic [CNT_W-1:0]  LD_E_LO   = CNT_W'(E_LOW_CYC);
   localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(BUSY_MAX);

   typedef enum logic [2:0] {
      IDLE, SETUP, E_HI, E_LO, BSY_SETUP, BSY_E_HI, BSY_E_LO, DONE
   } state_t;

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic [POLL_W-1:0] poll_cnt;
   logic              rw_q;
   logic              nib_lo;
   logic              busy_q;
   logic [7:0]        data_q;
   logic [7:0]        rd_q;

   function automatic logic [7:0] bus_val(input logic [7:0] b, input logic lo);
      if (BUS_4BIT == 0)
         return b;
      return lo ? {b[3:0], 4'h0} : {b[7:4], 4'h0};
   endfunction

   assign req_ready = (state == IDLE);

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state         <= IDLE;
         cnt           <= '0;
         poll_cnt      <= '0;
         rw_q          <= 1'b0;
         nib_lo        <= 1'b0;
         busy_q        <= 1'b0;
         data_q        <= '0;
         rd_q          <= '0;
         LCD1602_RS    <= 1'b0;
         LCD1602_RW    <= 1'b0;
         LCD1602_E     <= 1'b0;
         LCD1602_DB_o  <= '0;
         LCD1602_DB_oe <= 1'b0;
         done          <= 1'b0;
         done_err      <= 1'b0;
         rsp_data      <= '0;
      end else begin
         done     <= 1'b0;
         done_err <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  rw_q          <= req_rw;
                  data_q        <= req_data;
                  nib_lo        <= 1'b0;
                  cnt           <= LD_SETUP;
                  state         <= SETUP;
                  LCD1602_RS    <= req_rs;
                  LCD1602_RW    <= req_rw;
                  LCD1602_DB_oe <= ~req_rw;
                  LCD1602_DB_o  <= req_rw ? 8'h00 : bus_val(req_data, 1'b0);
               end
            end
            SETUP, BSY_SETUP: begin
               if (cnt == '0) begin
                  state     <= (state == SETUP) ? E_HI : BSY_E_HI;
                  cnt       <= LD_E_HI;
                  LCD1602_E <= 1'b1;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            E_HI, BSY_E_HI: begin
               if (cnt == '0) begin
                  state     <= (state == E_HI) ? E_LO : BSY_E_LO;
                  cnt       <= LD_E_LO;
                  LCD1602_E <= 1'b0;
                  // Bus is sampled on the last cycle E is high, just before it falls
                  if (state == BSY_E_HI) begin
                     if (!nib_lo)
                        busy_q <= LCD1602_DB_i[7];
                  end else if (rw_q) begin
                     if (BUS_4BIT == 0)
                        rd_q <= LCD1602_DB_i;
                     else if (nib_lo)
                        rd_q[3:0] <= LCD1602_DB_i[7:4];
                     else
                        rd_q[7:4] <= LCD1602_DB_i[7:4];
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            E_LO: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else if (BUS_4BIT != 0 && !nib_lo) begin
                  nib_lo       <= 1'b1;
                  state        <= SETUP;
                  cnt          <= LD_SETUP;
                  LCD1602_DB_o <= rw_q ? 8'h00 : bus_val(data_q, 1'b1);
               end else if (POLL_BUSY != 0 && !rw_q) begin
                  nib_lo        <= 1'b0;
                  poll_cnt      <= POLL_W'(1);
                  state         <= BSY_SETUP;
                  cnt           <= LD_SETUP;
                  LCD1602_RS    <= 1'b0;
                  LCD1602_RW    <= 1'b1;
                  LCD1602_DB_oe <= 1'b0;
                  LCD1602_DB_o  <= 8'h00;
               end else begin
                  state         <= DONE;
                  done          <= 1'b1;
                  rsp_data      <= rd_q;
                  LCD1602_RS    <= 1'b0;
                  LCD1602_RW    <= 1'b0;
                  LCD1602_DB_oe <= 1'b0;
                  LCD1602_DB_o  <= 8'h00;
               end
            end
            BSY_E_LO: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else if (BUS_4BIT != 0 && !nib_lo) begin
                  nib_lo <= 1'b1;
                  state  <= BSY_SETUP;
                  cnt    <= LD_SETUP;
               end else if (!busy_q || poll_cnt == POLL_LAST) begin
                  state      <= DONE;
                  done       <= 1'b1;
                  done_err   <= busy_q;
                  rsp_data   <= rd_q;
                  LCD1602_RS <= 1'b0;
                  LCD1602_RW <= 1'b0;
               end else begin
                  poll_cnt <= poll_cnt + 1'b1;
                  nib_lo   <= 1'b0;
                  state    <= BSY_SETUP;
                  cnt      <= LD_SETUP;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule
